// File: rtl/mrd_fsmwr_back.sv
// Mixed-radix write-back: realigns each read beat's per-lane bank index/address
// with the butterfly results and scatters the five lane results into seven banks.
module mrd_fsmwr_back #(
  parameter int unsigned wDATA   = 30,
  parameter int unsigned wADDR   = 9,
  parameter int unsigned RDX_DLY = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             fsm,
  input  logic                   rd_valid,
  input  logic [4:0][2:0]        rd_bank_index,
  input  logic [4:0][wADDR-1:0]  rd_bank_addr,
  input  logic [2:0]             rd_factor,
  input  logic                   rdx_valid,
  input  logic [4:0][wDATA-1:0]  rdx_d_real,
  input  logic [4:0][wDATA-1:0]  rdx_d_imag,
  output logic [6:0]             wren,
  output logic [6:0][wADDR-1:0]  wraddr,
  output logic [6:0][wDATA-1:0]  wdata_real,
  output logic [6:0][wDATA-1:0]  wdata_imag,
  output logic                   wr_end,
  output logic [11:0]            wr_cnt,
  output logic                   err_align,
  output logic                   err_collision
);

  typedef enum logic [2:0] {
    FSM_IDLE        = 3'd0,
    FSM_RD          = 3'd3,
    FSM_WAIT_WR_END = 3'd4,
    FSM_SOURCE      = 3'd5
  } fsm_e;

  typedef struct packed {
    logic                  valid;
    logic [4:0][2:0]       index;
    logic [4:0][wADDR-1:0] addr;
    logic [2:0]            factor;
  } dly_t;

  localparam dly_t DLY_EMPTY = '{valid: 1'b0, index: '1, addr: '0, factor: '0};

  fsm_e                  w_fsm;
  logic                  w_idle;
  dly_t                  r_dly [RDX_DLY];
  dly_t                  w_tap;
  logic [4:0]            w_act;
  logic [6:0]            w_hit;
  logic [6:0][wADDR-1:0] w_addr;
  logic [6:0][wDATA-1:0] w_re;
  logic [6:0][wDATA-1:0] w_im;
  logic                  w_coll;
  logic                  w_beat;

  logic [6:0]            r_wren;
  logic [6:0][wADDR-1:0] r_wraddr;
  logic [6:0][wDATA-1:0] r_wdata_real;
  logic [6:0][wDATA-1:0] r_wdata_imag;
  logic                  r_beat_wr;
  logic                  r_wr_end;
  logic [11:0]           r_wr_cnt;
  logic                  r_err_align;
  logic                  r_err_collision;

  assign w_fsm  = fsm_e'(fsm);
  assign w_idle = (w_fsm == FSM_IDLE);
  assign w_tap  = r_dly[RDX_DLY-1];
  assign w_beat = rdx_valid & w_tap.valid & ~w_idle;

  always_ff @(posedge clk) begin
    if (!rst_n || w_idle) begin
      for (int unsigned i = 0; i < RDX_DLY; i++) r_dly[i] <= DLY_EMPTY;
    end else begin
      r_dly[0] <= '{valid: rd_valid, index: rd_bank_index, addr: rd_bank_addr, factor: rd_factor};
      for (int unsigned i = 1; i < RDX_DLY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  always_comb begin
    w_act  = '0;
    w_hit  = '0;
    w_addr = '0;
    w_re   = '0;
    w_im   = '0;
    w_coll = 1'b0;
    for (int unsigned l = 0; l < 5; l++) begin
      w_act[l] = w_tap.valid && (w_tap.index[l] != 3'd7) && (3'(l) < w_tap.factor);
    end
    // Lanes scanned high to low so the lowest-numbered active lane is written last and wins.
    for (int unsigned k = 0; k < 7; k++) begin
      for (int unsigned j = 0; j < 5; j++) begin
        if (w_act[4-j] && (w_tap.index[4-j] == 3'(k))) begin
          if (w_hit[k]) w_coll = 1'b1;
          w_hit[k]  = 1'b1;
          w_addr[k] = w_tap.addr[4-j];
          w_re[k]   = rdx_d_real[4-j];
          w_im[k]   = rdx_d_imag[4-j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wren          <= '0;
      r_wraddr        <= '0;
      r_wdata_real    <= '0;
      r_wdata_imag    <= '0;
      r_beat_wr       <= 1'b0;
      r_wr_end        <= 1'b0;
      r_wr_cnt        <= '0;
      r_err_align     <= 1'b0;
      r_err_collision <= 1'b0;
    end else begin
      r_wren       <= w_hit & {7{w_beat}};
      r_wraddr     <= w_beat ? w_addr : '0;
      r_wdata_real <= w_beat ? w_re : '0;
      r_wdata_imag <= w_beat ? w_im : '0;
      r_beat_wr    <= w_beat;
      r_wr_end     <= r_beat_wr & ~w_beat & ~w_idle;

      // A beat landing on the clear cycle starts the next count instead of being lost.
      if (w_idle)                             r_wr_cnt <= '0;
      else if (r_wr_end)                      r_wr_cnt <= w_beat ? 12'd1 : 12'd0;
      else if (w_beat && (r_wr_cnt != '1))    r_wr_cnt <= r_wr_cnt + 12'd1;

      if (w_idle) begin
        r_err_align     <= 1'b0;
        r_err_collision <= 1'b0;
      end else begin
        if (rdx_valid != w_tap.valid) r_err_align     <= 1'b1;
        if (rdx_valid && w_coll)      r_err_collision <= 1'b1;
      end
    end
  end

  assign wren          = r_wren;
  assign wraddr        = r_wraddr;
  assign wdata_real    = r_wdata_real;
  assign wdata_imag    = r_wdata_imag;
  assign wr_end        = r_wr_end;
  assign wr_cnt        = r_wr_cnt;
  assign err_align     = r_err_align;
  assign err_collision = r_err_collision;

endmodule

// File: tb/tb_mrd_fsmwr_back.sv
// Self-checking bench for mrd_fsmwr_back: directed scenarios plus randomized
// traffic, all compared against a time-indexed behavioural model.
module tb_mrd_fsmwr_back;

  localparam int unsigned WD  = 30;
  localparam int unsigned WA  = 9;
  localparam int unsigned DLY = 8;
  localparam int VW = 7 + 7*WA + 14*WD + 1 + 12 + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           fsm;
  logic                 rd_valid;
  logic [4:0][2:0]      rd_bank_index;
  logic [4:0][WA-1:0]   rd_bank_addr;
  logic [2:0]           rd_factor;
  logic                 rdx_valid;
  logic [4:0][WD-1:0]   rdx_d_real;
  logic [4:0][WD-1:0]   rdx_d_imag;
  logic [6:0]           wren;
  logic [6:0][WA-1:0]   wraddr;
  logic [6:0][WD-1:0]   wdata_real;
  logic [6:0][WD-1:0]   wdata_imag;
  logic                 wr_end;
  logic [11:0]          wr_cnt;
  logic                 err_align;
  logic                 err_collision;

  mrd_fsmwr_back #(.wDATA(WD), .wADDR(WA), .RDX_DLY(DLY)) dut (
    .clk(clk), .rst_n(rst_n), .fsm(fsm), .rd_valid(rd_valid),
    .rd_bank_index(rd_bank_index), .rd_bank_addr(rd_bank_addr), .rd_factor(rd_factor),
    .rdx_valid(rdx_valid), .rdx_d_real(rdx_d_real), .rdx_d_imag(rdx_d_imag),
    .wren(wren), .wraddr(wraddr), .wdata_real(wdata_real), .wdata_imag(wdata_imag),
    .wr_end(wr_end), .wr_cnt(wr_cnt), .err_align(err_align), .err_collision(err_collision)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remembers what was presented on every edge and looks back DLY edges.
  logic [6:0]         m_wren;
  logic [6:0][WA-1:0] m_addr;
  logic [6:0][WD-1:0] m_re;
  logic [6:0][WD-1:0] m_im;
  logic               m_end, m_align, m_coll, m_prev_beat;
  logic [11:0]        m_cnt;
  int                 n_edge = 0;
  int                 last_clr = 0;
  logic               h_v   [32];
  logic [4:0][2:0]    h_idx [32];
  logic [4:0][WA-1:0] h_addr[32];
  logic [2:0]         h_fac [32];

  logic [VW-1:0] dut_vec, exp_vec;
  assign dut_vec = {wren, wraddr, wdata_real, wdata_imag, wr_end, wr_cnt, err_align, err_collision};
  assign exp_vec = {m_wren, m_addr, m_re, m_im, m_end, m_cnt, m_align, m_coll};

  initial begin : ref_model
    int m, mi, hits, slot;
    bit tv, idle, beat, end_prev;
    for (int i = 0; i < 32; i++) begin
      h_v[i] = 1'b0; h_idx[i] = '1; h_addr[i] = '0; h_fac[i] = '0;
    end
    m_wren = '0; m_addr = '0; m_re = '0; m_im = '0;
    m_end = 1'b0; m_align = 1'b0; m_coll = 1'b0; m_prev_beat = 1'b0; m_cnt = '0;
    forever begin
      @(posedge clk);
      m  = n_edge - int'(DLY);
      mi = (m < 0) ? 0 : (m % 32);
      if (!rst_n) begin
        m_wren = '0; m_addr = '0; m_re = '0; m_im = '0;
        m_end = 1'b0; m_align = 1'b0; m_coll = 1'b0; m_prev_beat = 1'b0; m_cnt = '0;
        last_clr = n_edge;
      end else begin
        idle = (fsm == 3'd0);
        tv   = (m >= 0) && (m > last_clr) && (h_v[mi] == 1'b1);
        beat = rdx_valid && tv && !idle;
        m_wren = '0; m_addr = '0; m_re = '0; m_im = '0;
        for (int k = 0; k < 7; k++) begin
          hits = 0;
          for (int l = 0; l < 5; l++) begin
            if (tv && (l < int'(h_fac[mi])) && (h_idx[mi][l] != 3'd7) && (int'(h_idx[mi][l]) == k)) begin
              if (hits == 0 && beat) begin
                m_wren[k] = 1'b1;
                m_addr[k] = h_addr[mi][l];
                m_re[k]   = rdx_d_real[l];
                m_im[k]   = rdx_d_imag[l];
              end
              hits++;
            end
          end
          if (!idle && hits > 1 && rdx_valid) m_coll = 1'b1;
        end
        if (idle) begin
          m_align = 1'b0; m_coll = 1'b0;
        end else if (rdx_valid != tv) begin
          m_align = 1'b1;
        end
        end_prev    = m_end;
        m_end       = m_prev_beat && !beat && !idle;
        m_prev_beat = beat;
        if (idle)                          m_cnt = '0;
        else if (end_prev)                 m_cnt = beat ? 12'd1 : 12'd0;
        else if (beat && m_cnt != 12'hFFF) m_cnt = m_cnt + 12'd1;
        if (idle) last_clr = n_edge;
      end
      slot = n_edge % 32;
      h_v[slot] = rd_valid; h_idx[slot] = rd_bank_index;
      h_addr[slot] = rd_bank_addr; h_fac[slot] = rd_factor;
      n_edge++;
    end
  end

  task automatic quiet();
    rd_valid = 1'b0; rdx_valid = 1'b0; rd_bank_index = '1; rd_bank_addr = '0;
    rd_factor = 3'd2; rdx_d_real = '0; rdx_d_imag = '0;
  endtask

  task automatic rand_payload();
    for (int l = 0; l < 5; l++) begin
      rd_bank_addr[l] = WA'($urandom);
      rdx_d_real[l]   = WD'($urandom);
      rdx_d_imag[l]   = WD'($urandom);
    end
  endtask

  task automatic go_idle(input int n);
    fsm = 3'd0;
    quiet();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fsm = 3'd3; rd_valid = 1'b1; rdx_valid = 1'b1;
    rd_factor = 3'd5; rd_bank_index = '0; rand_payload();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_zero cyc=%0d got=%h exp=0", i, dut_vec); end
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec); end
    end
    rst_n = 1'b1;
    go_idle(2);
  endtask

  task automatic test_single_beat();
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL single_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (i == 9) begin
        n_tests++; if (wren !== 7'b0011111) begin n_fail++; $display("FAIL single_wren got=%b exp=0011111", wren); end
        n_tests++; if (wraddr[2] !== 9'd7) begin n_fail++; $display("FAIL single_wraddr2 got=%0d exp=7", wraddr[2]); end
        n_tests++; if (wdata_real[2] !== 30'd12) begin n_fail++; $display("FAIL single_wdata2 got=%0d exp=12", wdata_real[2]); end
        n_tests++; if (wr_cnt !== 12'd1) begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", wr_cnt); end
        n_tests++; if (wr_end !== 1'b0) begin n_fail++; $display("FAIL single_end_early got=%b exp=0", wr_end); end
      end
      if (i == 10) begin
        n_tests++; if (wr_end !== 1'b1) begin n_fail++; $display("FAIL single_end got=%b exp=1", wr_end); end
        n_tests++; if (wren !== 7'b0) begin n_fail++; $display("FAIL single_wren_off got=%b exp=0", wren); end
      end
      if (i == 11) begin
        n_tests++; if (wr_cnt !== 12'd0) begin n_fail++; $display("FAIL single_cnt_clr got=%0d exp=0", wr_cnt); end
      end
      fsm = 3'd3; rand_payload();
      rd_valid = (i == 0); rdx_valid = (i == 8); rd_factor = 3'd5;
      for (int l = 0; l < 5; l++) begin
        rd_bank_index[l] = 3'(l);
        rd_bank_addr[l]  = WA'(5 + l);
        rdx_d_real[l]    = WD'(10 + l);
      end
    end
    go_idle(2);
  endtask

  task automatic test_radix3();
    logic [4:0][2:0] idx;
    idx = {3'd2, 3'd1, 3'd4, 3'd0, 3'd6};
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL radix3_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (i == 9) begin
        n_tests++; if (wren !== 7'b1010001) begin n_fail++; $display("FAIL radix3_wren got=%b exp=1010001", wren); end
        n_tests++; if ({wraddr[1], wraddr[2], wdata_real[1], wdata_real[2]} !== '0) begin
          n_fail++; $display("FAIL radix3_masked got=%h exp=0", {wraddr[1], wraddr[2], wdata_real[1], wdata_real[2]}); end
        n_tests++; if (err_collision !== 1'b0) begin n_fail++; $display("FAIL radix3_coll got=%b exp=0", err_collision); end
      end
      fsm = 3'd3; rand_payload();
      rd_valid = (i == 0); rdx_valid = (i == 8); rd_factor = 3'd3; rd_bank_index = idx;
    end
    go_idle(2);
  endtask

  task automatic test_collision();
    logic [WD-1:0] lane0_re;
    logic [WA-1:0] lane0_addr;
    lane0_re = '0; lane0_addr = '0;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL coll_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (i == 9) begin
        n_tests++; if (wren !== 7'b0101000) begin n_fail++; $display("FAIL coll_wren got=%b exp=0101000", wren); end
        n_tests++; if (wdata_real[3] !== lane0_re) begin n_fail++; $display("FAIL coll_lane0_data got=%h exp=%h", wdata_real[3], lane0_re); end
        n_tests++; if (wraddr[3] !== lane0_addr) begin n_fail++; $display("FAIL coll_lane0_addr got=%h exp=%h", wraddr[3], lane0_addr); end
        n_tests++; if (err_collision !== 1'b1) begin n_fail++; $display("FAIL coll_flag got=%b exp=1", err_collision); end
      end
      if (i == 12) begin
        n_tests++; if (err_collision !== 1'b1) begin n_fail++; $display("FAIL coll_sticky got=%b exp=1", err_collision); end
      end
      fsm = (i < 10) ? 3'd3 : 3'd4; rand_payload();
      rd_valid = (i == 0); rdx_valid = (i == 8); rd_factor = 3'd4;
      rd_bank_index = {3'($urandom_range(0, 7)), 3'd7, 3'd5, 3'd3, 3'd3};
      if (i == 0) lane0_addr = rd_bank_addr[0];
      if (i == 8) lane0_re = rdx_d_real[0];
    end
    fsm = 3'd0; quiet();
    @(negedge clk);
    n_tests++; if (err_collision !== 1'b0) begin n_fail++; $display("FAIL coll_idle_clr got=%b exp=0", err_collision); end
    go_idle(1);
  endtask

  task automatic test_burst();
    int n_end, end_at;
    n_end = 0; end_at = -1;
    for (int i = 0; i <= 112; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL burst_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (wr_end === 1'b1) begin n_end++; end_at = i; end
      if (i == 108) begin
        n_tests++; if (wr_cnt !== 12'd100) begin n_fail++; $display("FAIL burst_cnt got=%0d exp=100", wr_cnt); end
        n_tests++; if (wren === 7'b0) begin n_fail++; $display("FAIL burst_last_wren got=%b exp=nonzero", wren); end
      end
      if (i == 110) begin
        n_tests++; if (wr_cnt !== 12'd0) begin n_fail++; $display("FAIL burst_cnt_clr got=%0d exp=0", wr_cnt); end
      end
      fsm = (i < 100) ? 3'd3 : 3'd4; rand_payload();
      rd_valid = (i < 100); rdx_valid = (i >= 8 && i < 108); rd_factor = 3'd4;
      for (int l = 0; l < 4; l++) rd_bank_index[l] = 3'((i + l) % 7);
      rd_bank_index[4] = 3'd7;
    end
    n_tests++; if (n_end != 1) begin n_fail++; $display("FAIL burst_end_count got=%0d exp=1", n_end); end
    n_tests++; if (end_at != 109) begin n_fail++; $display("FAIL burst_end_pos got=%0d exp=109", end_at); end
    go_idle(2);
  endtask

  task automatic test_misalign();
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL misalign_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (i == 7) begin
        n_tests++; if (err_align !== 1'b0) begin n_fail++; $display("FAIL misalign_early got=%b exp=0", err_align); end
      end
      if (i == 8) begin
        n_tests++; if (err_align !== 1'b1) begin n_fail++; $display("FAIL misalign_flag got=%b exp=1", err_align); end
      end
      if (i >= 8 && i <= 10) begin
        n_tests++; if (wren !== 7'b0) begin n_fail++; $display("FAIL misalign_wren cyc=%0d got=%b exp=0", i, wren); end
      end
      fsm = 3'd3; rand_payload();
      rd_valid = (i == 0); rdx_valid = (i == 7); rd_factor = 3'd5;
      for (int l = 0; l < 5; l++) rd_bank_index[l] = 3'(l);
    end
    go_idle(2);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i <= 62; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (i == 51) begin
        n_tests++; if (dut_vec !== '0) begin n_fail++; $display("FAIL rstmid_zero got=%h exp=0", dut_vec); end
      end
      if (i >= 52) begin
        n_tests++;
        if ({wren, wr_end} !== 8'b0) begin n_fail++; $display("FAIL rstmid_spurious cyc=%0d got=%b exp=0", i, {wren, wr_end}); end
      end
      rand_payload(); rd_factor = 3'd4;
      for (int l = 0; l < 4; l++) rd_bank_index[l] = 3'((i + 2*l) % 7);
      rd_bank_index[4] = 3'd7;
      if (i < 50) begin
        rst_n = 1'b1; fsm = 3'd3; rd_valid = 1'b1; rdx_valid = (i >= 8);
      end else if (i == 50) begin
        rst_n = 1'b0; fsm = 3'd0; rd_valid = 1'b0; rdx_valid = 1'b0;
      end else if (i == 51) begin
        rst_n = 1'b1; fsm = 3'd0; rd_valid = 1'b0; rdx_valid = 1'b0;
      end else begin
        rst_n = 1'b1; fsm = 3'd3; rd_valid = 1'b0; rdx_valid = (i <= 60);
      end
    end
    go_idle(2);
  endtask

  task automatic test_random();
    logic [DLY-1:0] rvh;
    rvh = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      fsm = ($urandom_range(0, 99) < 3) ? 3'd0 : 3'($urandom_range(3, 5));
      rd_valid  = ($urandom_range(0, 9) < 8);
      rd_factor = 3'($urandom_range(2, 5));
      for (int l = 0; l < 5; l++) rd_bank_index[l] = 3'($urandom_range(0, 7));
      rand_payload();
      rdx_valid = rvh[DLY-1] ^ ($urandom_range(0, 49) == 0);
      rvh = {rvh[DLY-2:0], rd_valid};
    end
    go_idle(2);
  endtask

  task automatic test_saturate();
    for (int i = 0; i <= 4110; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL sat_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec); end
      if (i == 4108) begin
        n_tests++; if (wr_cnt !== 12'd4095) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=4095", wr_cnt); end
      end
      fsm = 3'd3; rand_payload();
      rd_valid = (i < 4100); rdx_valid = (i >= 8 && i < 4108); rd_factor = 3'd2;
      rd_bank_index = {3'd7, 3'd7, 3'd7, 3'(($urandom_range(0, 2)) + 3), 3'($urandom_range(0, 2))};
    end
    go_idle(2);
  endtask

  initial begin
    rst_n = 1'b0; fsm = 3'd0; quiet();
    test_reset();
    test_single_beat();
    test_radix3();
    test_collision();
    test_burst();
    test_misalign();
    test_reset_mid_burst();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
